axis_uart_bridge_rx: RTL and testbench

AXIS_UART_BRIDGE_RX -- requirements
Module: axis_uart_bridge_rx

---
 rtl/axis_uart_bridge_rx.sv | 204 ++++++++++++++++++++
 tb/tb_axis_uart_bridge_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_bridge_rx.sv
// UART receiver (8N1) that packs N_BYTES received bytes, first byte in the low lane, into one AXI-Stream beat.
// Optional inter-byte timeout for partial words: define AXIS_UART_BRIDGE_RX_TIMEOUT_EN.
module axis_uart_bridge_rx #(
    parameter int UART_SPEED   = 115200,
    parameter int FREQ_HZ      = 100000000,
    parameter int N_BYTES      = 32,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   UART_RX,
    output logic [N_BYTES*8-1:0]   M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   FRAME_ERR,
    output logic                   OVERFLOW
);

    localparam int BIT_TICKS = FREQ_HZ / UART_SPEED;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int TICK_W    = $clog2(BIT_TICKS + 1);
    localparam int CNT_W     = $clog2(N_BYTES + 1);
    localparam int WORD_W    = N_BYTES * 8;

    localparam logic [TICK_W-1:0] TICK_HALF_M1 = TICK_W'(HALF - 1);
    localparam logic [TICK_W-1:0] TICK_BIT_M1  = TICK_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(N_BYTES - 1);

    // The start-bit mid-point sample needs at least two ticks per bit; a zero timeout is meaningless.
    if (BIT_TICKS < 2 || TIMEOUT_BITS < 1) begin : g_bad_params
        $error("axis_uart_bridge_rx: FREQ_HZ/UART_SPEED must be >= 2 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q,     state_d;
    logic                rx_meta_q,   rx_meta_d;
    logic                rx_sync_q,   rx_sync_d;
    logic                rx_last_q,   rx_last_d;
    logic [TICK_W-1:0]   tick_q,      tick_d;
    logic [2:0]          bit_idx_q,   bit_idx_d;
    logic [7:0]          shift_q,     shift_d;
    logic [CNT_W-1:0]    byte_cnt_q,  byte_cnt_d;
    logic [WORD_W-1:0]   word_q,      word_d;
    logic [WORD_W-1:0]   tdata_q,     tdata_d;
    logic                tvalid_q,    tvalid_d;
    logic                frame_err_q, frame_err_d;
    logic                overflow_q,  overflow_d;
    logic                fall_edge;

`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * BIT_TICKS;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0]     idle_cnt_q,  idle_cnt_d;
`endif

    assign fall_edge = rx_last_q & ~rx_sync_q;

    // NOTE: every _d gets a default on entry so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        rx_meta_d   = UART_RX;
        rx_sync_d   = rx_meta_q;
        rx_last_d   = rx_sync_q;
        tick_d      = tick_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;

        if (tvalid_q && M_AXIS_TREADY) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick_q == TICK_HALF_M1) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_q == TICK_BIT_M1) begin
                    tick_d    = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_q == TICK_BIT_M1) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (rx_sync_q) begin
                        for (int k = 0; k < N_BYTES; k++) begin
                            if (byte_cnt_q == CNT_W'(k)) begin
                                word_d[k*8 +: 8] = shift_q;
                            end
                        end
                        if (byte_cnt_q == CNT_LAST) begin
                            byte_cnt_d = '0;
                            // A full word only replaces the output if the old one is gone this cycle.
                            if (!tvalid_q || M_AXIS_TREADY) begin
                                tdata_d  = word_d;
                                tvalid_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        byte_cnt_d  = '0;
                        word_d      = '0;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
        idle_cnt_d = '0;
        if (state_q == IDLE && byte_cnt_q != '0 && !fall_edge) begin
            if (idle_cnt_q == TO_LAST) begin
                byte_cnt_d = '0;
                word_d     = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_last_q   <= 1'b1;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_last_q   <= rx_last_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign FRAME_ERR     = frame_err_q;
    assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_axis_uart_bridge_rx.sv
// Scoreboard bench for axis_uart_bridge_rx at 10 ticks per bit, 4 bytes per word.
// Define AXIS_UART_BRIDGE_RX_TIMEOUT_EN to include the partial-word timeout scenario.
`timescale 1ns/1ps
module tb_axis_uart_bridge_rx;

    localparam int N_BYTES = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 uart_rx;
    logic [N_BYTES*8-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 frame_err;
    logic                 overflow;

    int          n_vec = 0;
    int          n_err = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    logic [31:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [31:0] held_data  = '0;

    axis_uart_bridge_rx #(
        .UART_SPEED  (10000000),
        .FREQ_HZ     (100000000),
        .N_BYTES     (N_BYTES),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .UART_RX      (uart_rx),
        .M_AXIS_TDATA (m_axis_tdata),
        .M_AXIS_TVALID(m_axis_tvalid),
        .M_AXIS_TREADY(m_axis_tready),
        .FRAME_ERR    (frame_err),
        .OVERFLOW     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(10);
        end
        uart_rx = stop;
        tick(10);
        uart_rx = 1'b1;
        tick(4);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (m_axis_tvalid) begin
                if (stall_prev) check("tdata_hold", m_axis_tdata, held_data);
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_axis_tdata);
                    end else begin
                        check("beat_tdata", m_axis_tdata, exp_q.pop_front());
                    end
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held_data  = m_axis_tdata;
            if (frame_err) fe_cnt++;
            if (overflow)  ov_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        uart_rx       = 1'b1;
        m_axis_tready = 1'b0;
        tick(3);
        check("rst_tvalid",    m_axis_tvalid, 0);
        check("rst_tdata",     m_axis_tdata,  0);
        check("rst_frame_err", frame_err,     0);
        check("rst_overflow",  overflow,      0);
        reset = 1'b0;
        tick(5);

        // One word with a ready sink.
        m_axis_tready = 1'b1;
        exp_q.push_back(32'h4433_2211);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        tick(5);
        check("t1_tvalid_low", m_axis_tvalid, 0);
        check("t1_no_fe",      fe_cnt, 0);

        // Short low glitch must not start a byte.
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(30);
        check("glitch_no_fe",     fe_cnt, 0);
        check("glitch_no_valid",  m_axis_tvalid, 0);
        check("glitch_state",     dut.state_q, 0);

        // Stalled sink: second word is dropped with one overflow pulse.
        m_axis_tready = 1'b0;
        exp_q.push_back(32'h0403_0201);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        tick(5);
        check("ovf_count",      ov_cnt, 1);
        check("ovf_tvalid",     m_axis_tvalid, 1);
        check("ovf_tdata_kept", m_axis_tdata, 32'h0403_0201);
        m_axis_tready = 1'b1;
        tick(5);
        check("ovf_drained",    m_axis_tvalid, 0);

        // Bad stop bit discards the byte; the next four bytes form a clean word.
        send_byte(8'hA5, 1'b0);
        tick(5);
        check("fe_count", fe_cnt, 1);
        exp_q.push_back(32'h0403_0201);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        tick(5);
        check("fe_once",  fe_cnt, 1);

        // Reset during bit 4 of byte 2 clears the partial word.
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            tick(10);
        end
        uart_rx = 1'b0;
        tick(3);
        reset   = 1'b1;
        uart_rx = 1'b1;
        tick(2);
        check("mid_rst_tdata",  m_axis_tdata,  0);
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        reset = 1'b0;
        tick(5);
        exp_q.push_back(32'hEFBE_ADDE);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        tick(5);

`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
        // Partial word times out after 4 idle bit periods.
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        tick(60);
        exp_q.push_back(32'h0D0C_0B0A);
        for (int i = 10; i <= 13; i++) send_byte(8'(i), 1'b1);
        tick(5);
        check("to_no_fe", fe_cnt, 1);
`endif

        tick(20);
        check("all_beats_seen", exp_q.size(), 0);
        check("final_ovf",      ov_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
